// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the sprite SRAM bus controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sram_ctrl_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned ADDR_W_DEF   = 18;
  localparam int unsigned READ_LAT_DEF = 2;

  // Bus sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  // Width of a down-counter that must hold the value lat
  function automatic int unsigned lat_cnt_w(input int unsigned lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/sram_lat_counter.sv
// Loadable down-counter that flags the final cycle of an SRAM read window.
// Latency: load takes effect on the next edge; last is a decode of the count register.
// Backpressure: none; decrements on every cycle dec is high.
module sram_lat_counter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned LAT = READ_LAT_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int unsigned CW = lat_cnt_w(LAT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Load the full window length, then count down toward one; hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(LAT);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A value of one means the current cycle is the last of the window
  assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/sram_bus_ctrl.sv
// Sequences single read/write requests onto the shared tristate SRAM bus with turnaround insertion.
// Latency: write occupies 1 cycle, read READ_LAT cycles then rsp_valid; +1 cycle when a turnaround is needed.
// Backpressure: req_ready is high only while idle; one operation outstanding, requester holds otherwise.
module sram_bus_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned READ_LAT = READ_LAT_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              bus_drive,
  output logic [DATA_W-1:0] bus_out,
  input  logic [DATA_W-1:0] bus_in
);

  state_e              state_q,      state_d;
  logic                req_ready_q,  req_ready_d;
  logic                rsp_valid_q,  rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q,   rsp_data_d;
  logic [ADDR_W-1:0]   sram_addr_q,  sram_addr_d;
  logic                we_n_q,       we_n_d;
  logic                oe_n_q,       oe_n_d;
  logic                drive_q,      drive_d;
  logic [DATA_W-1:0]   bus_out_q,    bus_out_d;
  // Latched request fields, kept across a turnaround cycle
  logic                op_we_q,      op_we_d;
  logic [DATA_W-1:0]   op_wdata_q,   op_wdata_d;
  // High during the first idle cycle after an operation completes
  logic                first_idle_q, first_idle_d;

  logic accept;
  logic cnt_load;
  logic cnt_dec;
  logic lat_last;

  assign accept = req_valid & req_ready_q;

  sram_lat_counter #(
    .LAT (READ_LAT)
  ) u_lat_cnt (
    .clock  (clock),
    .resetn (resetn),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .last   (lat_last)
  );

  // Next-state and registered-output decode; strobes default to inactive
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    sram_addr_d  = sram_addr_q;
    we_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    drive_d      = 1'b0;
    bus_out_d    = bus_out_q;
    op_we_d      = op_we_q;
    op_wdata_d   = op_wdata_q;
    first_idle_d = first_idle_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready_d  = 1'b1;
        // Only the very first idle cycle can trigger a turnaround
        first_idle_d = 1'b0;
        if (accept) begin
          req_ready_d = 1'b0;
          op_we_d     = req_we;
          op_wdata_d  = req_wdata;
          sram_addr_d = req_addr;
          if (first_idle_q && (req_we != op_we_q)) begin
            // Direction flip with no idle gap: let the bus settle first
            state_d = ST_TURN;
          end else if (req_we) begin
            state_d   = ST_WRITE;
            drive_d   = 1'b1;
            we_n_d    = 1'b0;
            bus_out_d = req_wdata;
          end else begin
            state_d  = ST_READ;
            oe_n_d   = 1'b0;
            cnt_load = 1'b1;
          end
        end
      end

      ST_TURN: begin
        if (op_we_q) begin
          state_d   = ST_WRITE;
          drive_d   = 1'b1;
          we_n_d    = 1'b0;
          bus_out_d = op_wdata_q;
        end else begin
          state_d  = ST_READ;
          oe_n_d   = 1'b0;
          cnt_load = 1'b1;
        end
      end

      ST_WRITE: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        first_idle_d = 1'b1;
      end

      ST_READ: begin
        cnt_dec = 1'b1;
        oe_n_d  = 1'b0;
        if (lat_last) begin
          // Data on the pads has been stable for the full latency window
          state_d      = ST_IDLE;
          oe_n_d       = 1'b1;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = bus_in;
          req_ready_d  = 1'b1;
          first_idle_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low clear
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      sram_addr_q  <= '0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      drive_q      <= 1'b0;
      bus_out_q    <= '0;
      op_we_q      <= 1'b0;
      op_wdata_q   <= '0;
      first_idle_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      sram_addr_q  <= sram_addr_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      drive_q      <= drive_d;
      bus_out_q    <= bus_out_d;
      op_we_q      <= op_we_d;
      op_wdata_q   <= op_wdata_d;
      first_idle_q <= first_idle_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign sram_addr = sram_addr_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign bus_drive = drive_q;
  assign bus_out   = bus_out_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Scoreboard bench for sram_bus_ctrl: directed requests, expected bus events queued, monitors compare.
// Latency: checks exact cycle of every write strobe and read response.
// Backpressure: requests are held until req_ready is seen high.
module tb_sram_bus_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 18;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic          bus_drive;
  logic [DW-1:0] bus_out;
  logic [DW-1:0] bus_in;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [31:0]   c;
  } wexp_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [31:0]   c;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int oe_cnt = 0;

  sram_bus_ctrl #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .READ_LAT (LAT)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .bus_drive (bus_drive),
    .bus_out   (bus_out),
    .bus_in    (bus_in)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // SRAM read model: data only valid once oe_n has been low for LAT-1 full cycles
  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    case (a)
      18'h00020: return 16'h1234;
      18'h00040: return 16'h4242;
      18'h00001: return 16'hAAAA;
      18'h00002: return 16'h5555;
      default:   return 16'h0BAD;
    endcase
  endfunction

  always @(posedge clock) begin
    if (sram_oe_n) oe_cnt <= 0;
    else           oe_cnt <= oe_cnt + 1;
  end

  assign bus_in = (!sram_oe_n && (oe_cnt >= LAT - 1)) ? mem_rd(sram_addr) : 16'hDEAD;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: protocol invariants, write strobes and read responses
  always @(negedge clock) begin
    chk("drv_oe_excl", 32'(bus_drive & ~sram_oe_n), 32'd0);
    chk("drv_only_wr", 32'(bus_drive & sram_we_n), 32'd0);
    if (!sram_we_n) begin
      if (wq.size() == 0) begin
        chk("unexp_we", 32'(sram_we_n), 32'd1);
      end else begin
        wexp_t w;
        w = wq.pop_front();
        chk("wr_addr",  32'(sram_addr), 32'(w.a));
        chk("wr_data",  32'(bus_out),   32'(w.d));
        chk("wr_drive", 32'(bus_drive), 32'd1);
        chk("wr_cycle", cyc, w.c);
      end
    end
    if (rsp_valid) begin
      if (rq.size() == 0) begin
        chk("unexp_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        rexp_t r;
        r = rq.pop_front();
        chk("rd_data",  32'(rsp_data), 32'(r.d));
        chk("rd_cycle", cyc, r.c);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rspv"},  32'(rsp_valid), 32'd0);
    chk({tag, "_rspd"},  32'(rsp_data),  32'd0);
    chk({tag, "_addr"},  32'(sram_addr), 32'd0);
    chk({tag, "_we_n"},  32'(sram_we_n), 32'd1);
    chk({tag, "_oe_n"},  32'(sram_oe_n), 32'd1);
    chk({tag, "_drive"}, 32'(bus_drive), 32'd0);
    chk({tag, "_bout"},  32'(bus_out),   32'd0);
  endtask

  // Wait for ready, idle 'gap' extra cycles, present one request, queue its expected bus event
  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] rd, input int turn, input int gap);
    int n;
    int acc;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    if (!req_ready) return;
    repeat (gap) @(negedge clock);
    acc       = cyc;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    if (we) wq.push_back('{a: a, d: wd, c: 32'(acc + 1 + turn)});
    else    rq.push_back('{d: rd, c: 32'(acc + LAT + 1 + turn)});
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clock);
    chk_reset_vals("rst");
    resetn = 1'b1;
    chk("rel_ready0", 32'(req_ready), 32'd0);
    @(negedge clock);
    chk("rel_ready1", 32'(req_ready), 32'd1);

    // Plain write, then a read after a long idle
    issue(1'b1, 18'h00010, 16'hBEEF, 16'h0000, 0, 0);
    issue(1'b0, 18'h00020, 16'h0000, 16'h1234, 0, 3);

    // Write immediately followed by read: turnaround cycle inserted
    issue(1'b1, 18'h00030, 16'hCAFE, 16'h0000, 0, 3);
    issue(1'b0, 18'h00040, 16'h0000, 16'h4242, 1, 0);
    @(negedge clock);
    chk("turn_drive", 32'(bus_drive), 32'd0);
    chk("turn_oe_n",  32'(sram_oe_n), 32'd1);
    chk("turn_we_n",  32'(sram_we_n), 32'd1);
    chk("turn_addr",  32'(sram_addr), 32'h00040);

    // Read then write with one idle cycle between: no turnaround
    issue(1'b1, 18'h00050, 16'h1111, 16'h0000, 0, 1);

    // Two back-to-back reads, second accepted while first response is shown
    issue(1'b0, 18'h00001, 16'h0000, 16'hAAAA, 0, 2);
    issue(1'b0, 18'h00002, 16'h0000, 16'h5555, 0, 0);

    // Read immediately followed by write: turnaround
    issue(1'b1, 18'h00060, 16'h2222, 16'h0000, 1, 0);

    // Reset during the first read cycle: the read is dropped
    issue(1'b0, 18'h00020, 16'h0000, 16'h1234, 0, 2);
    void'(rq.pop_back());
    resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk_reset_vals("mid");
    resetn = 1'b1;
    chk("mid_rel_ready0", 32'(req_ready), 32'd0);
    @(negedge clock);
    chk("mid_rel_ready1", 32'(req_ready), 32'd1);

    // Recovery: first op after reset never needs a turnaround
    issue(1'b1, 18'h00070, 16'h3333, 16'h0000, 0, 0);
    issue(1'b0, 18'h00001, 16'h0000, 16'hAAAA, 1, 0);

    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("rq_empty", 32'(rq.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    repeat (5) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_bus_ctrl.md
# sram_bus_ctrl

Sprite-memory bus controller: the read/control end of the shared bidirectional SRAM data bus whose pad drivers are tristate buffers. It accepts single read/write requests from the sprite pipeline, sequences SRAM address/strobes, asserts the tristate output enable only while writing, inserts a turnaround cycle on back-to-back direction changes, and captures read data from the bus after a fixed latency. It sits between the sprite fetch/update logic and the top-level SRAM pads.

## Interface
- DATA_W, 16, data bus width
- ADDR_W, 18, SRAM word address width
- READ_LAT, 2, cycles with oe_n low before bus_in is sampled (>=1)

- clock  in  1  system clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (registered)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_data  out  DATA_W  captured read data (held until next capture)
- sram_addr  out  ADDR_W  SRAM address
- sram_we_n  out  1  SRAM write strobe, active-low
- sram_oe_n  out  1  SRAM output enable, active-low
- bus_drive  out  1  output enable for the pad tristate buffers
- bus_out  out  DATA_W  data to pad tristates
- bus_in  in  DATA_W  data sampled from pads

## Operation
- States: IDLE, TURN, WRITE, READ. Reset -> IDLE.
- Accept = req_valid & req_ready at a rising edge; req_addr/req_we/req_wdata latched then. One op outstanding; req_ready=1 only in IDLE.
- IDLE: bus_drive=0, we_n=1, oe_n=1. On accept: TURN if turnaround needed, else WRITE or READ.
- Turnaround needed iff accept occurs in the first IDLE cycle after an op AND req_we differs from the previous op's direction. Any idle cycle longer than one, or first op after reset, needs no TURN.
- TURN: 1 cycle, bus_drive=0, we_n=1, oe_n=1, sram_addr already = latched addr; then WRITE/READ.
- WRITE: 1 cycle, sram_addr=addr, bus_out=wdata, bus_drive=1, we_n=0. -> IDLE. No response.
- READ: READ_LAT cycles, oe_n=0, bus_drive=0, sram_addr=addr. bus_in sampled at end of last READ cycle into rsp_data; rsp_valid=1 the following cycle (IDLE).
- bus_drive and oe_n are never both active; bus_drive=1 only in WRITE.
- Requests while req_ready=0 are ignored (requester holds).
- Reset mid-operation: op dropped, no rsp_valid, no we_n pulse after the reset edge; all outputs to reset values.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, sram_addr=0, sram_we_n=1, sram_oe_n=1, bus_drive=0, bus_out=0. req_ready rises the cycle after resetn deasserts.
- All outputs registered.
- Accept at edge E0. Write: WRITE in cycle E0..E1, req_ready=1 from E1. Read: READ cycles E0..E(READ_LAT); rsp_valid and req_ready=1 from E(READ_LAT)+1.
- Read latency accept->rsp_valid = READ_LAT+1 cycles; write occupancy 1 cycle; +1 each with TURN.
- New request may be accepted in the same cycle rsp_valid is high.

## Structure
- Shared package sram_ctrl_pkg: state enum (IDLE, TURN, WRITE, READ), default width constants.
- One sub-module: sram_lat_counter, loadable down-counter (width clog2(READ_LAT+1)) signalling the last READ cycle.
- Pad tristates instantiated at top level driven by bus_drive/bus_out; this block has no inout.

## Test plan
- Reset then write addr 0x00010, data 0xBEEF -> one cycle with we_n=0, bus_drive=1, bus_out=0xBEEF, sram_addr=0x00010; no rsp_valid.
- Read 0x00020, bench drives bus_in=0x1234 while oe_n=0 -> rsp_valid pulse READ_LAT+1 cycles after accept, rsp_data=0x1234.
- Write then read accepted back-to-back -> one TURN cycle (bus_drive=0, oe_n=1) between; read latency READ_LAT+2.
- Read then write with one idle gap -> no TURN; write occupies exactly 1 cycle; assert bus_drive & ~oe_n never true.
- Two back-to-back reads 0x1/0x2 returning 0xAAAA/0x5555 -> two rsp_valid pulses READ_LAT+1 apart, data in order, no TURN.
- resetn low during READ cycle 1 -> no rsp_valid, outputs at reset values, req_ready=1 one cycle after release.
